// File: rtl/stream_slice_packer.sv
// Collects BEATS words into one packet, applies a left/right streaming reorder with a
// runtime slice size, and presents the result on a valid/ready output.
module stream_slice_packer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BEATS     = 3,
  parameter int unsigned MAX_SLICE = 8,
  localparam int unsigned PW       = DATA_W * BEATS,
  localparam int unsigned SW       = $clog2(MAX_SLICE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_dir,
  input  logic [SW-1:0]     cfg_slice,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW-1:0]     out_data,
  output logic              busy,
  output logic              err_slice
);

  localparam int unsigned CW  = $clog2(BEATS + 1);
  localparam int unsigned SIW = (MAX_SLICE > 1) ? $clog2(MAX_SLICE) : 1;
  localparam logic [PW-1:0] BEAT_MASK = PW'({DATA_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REORDER = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   pkt_q, pkt_d;
  logic            dir_q, dir_d;
  logic [SIW-1:0]  sidx_q, sidx_d;
  logic [PW-1:0]   out_data_q, out_data_d;
  logic            err_slice_q, err_slice_d;

  logic            slice_legal_c;
  int unsigned     shift_c;
  logic [PW-1:0]   beat_wr_c;
  logic [PW-1:0]   reorder_c;
  logic [PW-1:0]   layout_c [MAX_SLICE];

  // One fixed wiring layout per slice size s: slice k = pkt[k*s +: w_k] lands with slice0 at the MSBs.
  for (genvar gs = 1; gs <= MAX_SLICE; gs++) begin : g_slice
    for (genvar gi = 0; gi < PW; gi++) begin : g_bit
      localparam int unsigned K   = gi / gs;
      localparam int unsigned W   = ((K + 1) * gs <= PW) ? gs : PW - K * gs;
      localparam int unsigned DST = PW - K * gs - W + (gi % gs);
      assign layout_c[gs-1][DST] = pkt_q[gi];
    end
  end

  assign reorder_c     = dir_q ? layout_c[sidx_q] : pkt_q;
  assign slice_legal_c = (cfg_slice != '0) && (cfg_slice <= SW'(MAX_SLICE));

  // First beat is most significant; count selects the slot counted down from the top.
  always_comb begin
    shift_c   = DATA_W * (BEATS - 1 - 32'(count_q));
    beat_wr_c = (pkt_q & ~(BEAT_MASK << shift_c)) | (PW'(in_data) << shift_c);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pkt_d       = pkt_q;
    dir_d       = dir_q;
    sidx_d      = sidx_q;
    out_data_d  = out_data_q;
    err_slice_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dir_d       = cfg_dir;
          sidx_d      = slice_legal_c ? SIW'(cfg_slice - SW'(1)) : '0;
          err_slice_d = !slice_legal_c;
          pkt_d       = beat_wr_c;
          count_d     = CW'(1);
          state_d     = (BEATS == 1) ? REORDER : COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          pkt_d   = beat_wr_c;
          count_d = count_q + CW'(1);
          if (count_q == CW'(BEATS - 1)) state_d = REORDER;
        end
      end
      REORDER: begin
        out_data_d = reorder_c;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pkt_q       <= '0;
      dir_q       <= 1'b0;
      sidx_q      <= '0;
      out_data_q  <= '0;
      err_slice_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pkt_q       <= pkt_d;
      dir_q       <= dir_d;
      sidx_q      <= sidx_d;
      out_data_q  <= out_data_d;
      err_slice_q <= err_slice_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign err_slice = err_slice_q;

endmodule
